// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM controller family: duty width, period
// length, ramp state encoding and the bounded-step helper.
package pwm_pkg;

  localparam int DUTY_W = 10;
  localparam logic [DUTY_W-1:0] PERIOD_MAX = 10'd1023;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } ramp_state_t;

  // Move cur toward tgt by at most step. The difference is taken one bit
  // wider than the duty so the direction is a plain sign bit and the result
  // can never wrap past full scale or below zero.
  function automatic logic [DUTY_W-1:0] ramp_step(
    input logic [DUTY_W-1:0] cur,
    input logic [DUTY_W-1:0] tgt,
    input logic [DUTY_W-1:0] step
  );
    logic [DUTY_W:0]   diff;
    logic [DUTY_W:0]   mag;
    logic [DUTY_W-1:0] amt;
    diff = {1'b0, tgt} - {1'b0, cur};
    mag  = diff[DUTY_W] ? (~diff + 1'b1) : diff;
    amt  = (mag > {1'b0, step}) ? step : mag[DUTY_W-1:0];
    return diff[DUTY_W] ? (cur - amt) : (cur + amt);
  endfunction

endpackage

// File: rtl/period_timer.sv
// Free-running PWM period counter with a tick on the last cycle of each
// period. Shared by every controller that must align to PWM periods.
module period_timer
  import pwm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  output logic [DUTY_W-1:0] cnt,
  output logic              period_tick
);

  // Count 0..PERIOD_MAX and wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      // NOTE: registers are written with <= so every flop samples the
      // pre-edge value of its inputs, independent of statement order.
      cnt <= (cnt == PERIOD_MAX) ? '0 : cnt + 1'b1;
    end
  end

  assign period_tick = (cnt == PERIOD_MAX);

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Duty ramp controller: accepts a target duty and walks the PWM duty toward
// it by at most STEP per PWM period, issuing one load pulse per change.
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter logic [DUTY_W-1:0] STEP = 10'd8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DUTY_W-1:0] target,
  input  logic              target_valid,
  output logic              target_ready,
  input  logic              stop,
  output logic [DUTY_W-1:0] data_out,
  output logic              load,
  output logic              busy,
  output logic              period_tick
);

  ramp_state_t       state;
  logic [DUTY_W-1:0] cur;
  logic [DUTY_W-1:0] tgt;
  logic              init_pending;
  logic [DUTY_W-1:0] tgt_eff;
  logic [DUTY_W-1:0] cur_next;
  // Only the tick is needed here; the count itself is left for other users.
  logic [DUTY_W-1:0] unused_cnt;

  period_timer u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .cnt         (unused_cnt),
    .period_tick (period_tick)
  );

  // A stop seen on a tick already ramps toward zero on that same tick.
  assign tgt_eff  = stop ? '0 : tgt;
  assign cur_next = ramp_step(cur, tgt_eff, STEP);

  assign target_ready = (state == IDLE);
  assign busy         = (state == RAMP);

  // Ramp state machine with registered load/data_out toward the PWM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cur          <= '0;
      tgt          <= '0;
      load         <= 1'b0;
      data_out     <= '0;
      init_pending <= 1'b1;
    end else begin
      // NOTE: load defaults low every cycle so it is a single-cycle pulse
      // unless one of the branches below raises it.
      load <= 1'b0;

      // First tick after reset defines the PWM duty register as zero.
      // cur is still zero here because ramp updates wait for this tick.
      if (period_tick && init_pending) begin
        init_pending <= 1'b0;
        load         <= 1'b1;
        data_out     <= '0;
      end

      case (state)
        IDLE: begin
          if (stop) begin
            tgt <= '0;
            if (cur != '0) state <= RAMP;
          end else if (target_valid) begin
            tgt <= target;
            if (target != cur) state <= RAMP;
          end
        end

        RAMP: begin
          if (stop) tgt <= '0;
          if (period_tick && !init_pending) begin
            if (cur_next != cur) begin
              cur      <= cur_next;
              load     <= 1'b1;
              data_out <= cur_next;
            end
            if (cur_next == tgt_eff) state <= IDLE;
          end else if (stop && (cur == '0)) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: a STEP=8 instance for ramp, stop and
// reset behaviour, and a STEP=1020 instance for full-scale boundaries.
module tb_pwm_ramp_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] a_target, b_target;
  logic       a_valid, b_valid, a_stop, b_stop;
  logic       a_ready, b_ready, a_load, b_load, a_busy, b_busy, a_tick, b_tick;
  logic [9:0] a_data, b_data;

  int checks = 0;
  int errors = 0;

  pwm_ramp_ctrl #(.STEP(10'd8)) dut_a (
    .clk(clk), .rst_n(rst_n), .target(a_target), .target_valid(a_valid),
    .target_ready(a_ready), .stop(a_stop), .data_out(a_data), .load(a_load),
    .busy(a_busy), .period_tick(a_tick)
  );

  pwm_ramp_ctrl #(.STEP(10'd1020)) dut_b (
    .clk(clk), .rst_n(rst_n), .target(b_target), .target_valid(b_valid),
    .target_ready(b_ready), .stop(b_stop), .data_out(b_data), .load(b_load),
    .busy(b_busy), .period_tick(b_tick)
  );

  // Wait (bounded) for the next load of one instance; cycles = negedges seen.
  task automatic wait_load(input bit sel_b, output logic [9:0] val, output int cycles);
    bit found = 1'b0;
    val = '0;
    cycles = 0;
    for (int i = 1; i <= 1100 && !found; i++) begin
      @(negedge clk);
      if ((sel_b ? b_load : a_load) === 1'b1) begin
        found = 1'b1;
        cycles = i;
        val = sel_b ? b_data : a_data;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL load_timeout dut=%0d: no load within 1100 cycles", sel_b);
    end
  endtask

  task automatic check_init_load();
    int first = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 1100 && first == 0; n++) begin
      @(negedge clk);
      if (n == 1023) begin
        checks++;
        if (a_tick !== 1'b1) begin
          errors++;
          $display("FAIL tick_at_1023 got %b want 1", a_tick);
        end
      end
      if (a_load === 1'b1) begin
        first = n;
        checks++;
        if (a_data !== 10'd0) begin
          errors++;
          $display("FAIL init_load_data got %0d want 0", a_data);
        end
        checks++;
        if (b_load !== 1'b1 || b_data !== 10'd0) begin
          errors++;
          $display("FAIL init_load_b got load=%b data=%0d want load=1 data=0", b_load, b_data);
        end
      end
    end
    checks++;
    if (first != 1024) begin
      errors++;
      $display("FAIL init_load_cycle got %0d want 1024", first);
    end
  endtask

  task automatic test_reset();
    a_target = '0; a_valid = 1'b0; a_stop = 1'b0;
    b_target = '0; b_valid = 1'b0; b_stop = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (a_ready !== 1'b1 || a_busy !== 1'b0 || a_tick !== 1'b0 || a_load !== 1'b0 || a_data !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs got ready=%b busy=%b tick=%b load=%b data=%0d want 1 0 0 0 0",
               a_ready, a_busy, a_tick, a_load, a_data);
    end
    check_init_load();
  endtask

  // Offer one target to instance A at the current negedge.
  task automatic offer_a(input logic [9:0] t, input logic with_stop);
    a_target = t;
    a_valid  = 1'b1;
    a_stop   = with_stop;
    @(negedge clk);
    a_valid = 1'b0;
    a_stop  = 1'b0;
  endtask

  task automatic expect_loads_a(input string name, input logic [9:0] exp_vals[$]);
    logic [9:0] v;
    int c;
    foreach (exp_vals[k]) begin
      wait_load(1'b0, v, c);
      checks++;
      if (v !== exp_vals[k]) begin
        errors++;
        $display("FAIL %s_load%0d got %0d want %0d", name, k, v, exp_vals[k]);
      end
      if (k > 0) begin
        checks++;
        if (c != 1024) begin
          errors++;
          $display("FAIL %s_spacing%0d got %0d want 1024", name, k, c);
        end
      end
    end
    checks++;
    if (a_busy !== 1'b0 || a_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_idle got busy=%b ready=%b want 0 1", name, a_busy, a_ready);
    end
  endtask

  task automatic test_ramp_up();
    checks++;
    if (a_ready !== 1'b1) begin
      errors++;
      $display("FAIL ramp_ready got %b want 1", a_ready);
    end
    offer_a(10'd20, 1'b0);
    checks++;
    if (a_busy !== 1'b1 || a_ready !== 1'b0) begin
      errors++;
      $display("FAIL ramp_busy got busy=%b ready=%b want 1 0", a_busy, a_ready);
    end
    expect_loads_a("ramp_up", '{10'd8, 10'd16, 10'd20});
  endtask

  task automatic test_same_target();
    int loads = 0;
    offer_a(10'd20, 1'b0);
    checks++;
    if (a_busy !== 1'b0 || a_ready !== 1'b1) begin
      errors++;
      $display("FAIL same_idle got busy=%b ready=%b want 0 1", a_busy, a_ready);
    end
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (a_load === 1'b1) loads++;
    end
    checks++;
    if (loads != 0) begin
      errors++;
      $display("FAIL same_no_load got %0d loads want 0", loads);
    end
  endtask

  task automatic test_stop_priority();
    offer_a(10'd500, 1'b1);
    checks++;
    if (a_busy !== 1'b1) begin
      errors++;
      $display("FAIL stop_busy got %b want 1", a_busy);
    end
    expect_loads_a("stop_idle", '{10'd12, 10'd4, 10'd0});
  endtask

  task automatic test_stop_mid_ramp();
    offer_a(10'd100, 1'b0);
    expect_loads_a_partial();
    offer_a(10'd500, 1'b1);
    expect_loads_a("stop_ramp", '{10'd32, 10'd24, 10'd16, 10'd8, 10'd0});
  endtask

  // Climb 0 -> 40 toward 100; still busy at the end.
  task automatic expect_loads_a_partial();
    logic [9:0] v;
    int c;
    for (int k = 1; k <= 5; k++) begin
      wait_load(1'b0, v, c);
      checks++;
      if (v !== 10'(8 * k)) begin
        errors++;
        $display("FAIL climb_load%0d got %0d want %0d", k, v, 8 * k);
      end
    end
    checks++;
    if (a_busy !== 1'b1) begin
      errors++;
      $display("FAIL climb_busy got %b want 1", a_busy);
    end
  endtask

  task automatic test_boundary();
    logic [9:0] seq [4] = '{10'd1020, 10'd1023, 10'd3, 10'd0};
    logic [9:0] v;
    int c;
    int extra = 0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (b_ready !== 1'b1) begin
        errors++;
        $display("FAIL bound_ready%0d got %b want 1", k, b_ready);
      end
      b_target = seq[k];
      b_valid  = 1'b1;
      @(negedge clk);
      b_valid = 1'b0;
      wait_load(1'b1, v, c);
      checks++;
      if (v !== seq[k] || b_busy !== 1'b0) begin
        errors++;
        $display("FAIL bound_load%0d got data=%0d busy=%b want data=%0d busy=0", k, v, b_busy, seq[k]);
      end
    end
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (b_load === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL bound_single got %0d extra loads want 0", extra);
    end
  endtask

  task automatic test_reset_mid_ramp();
    offer_a(10'd200, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      logic [9:0] v;
      int c;
      wait_load(1'b0, v, c);
      checks++;
      if (v !== 10'(8 * k)) begin
        errors++;
        $display("FAIL rst_climb%0d got %0d want %0d", k, v, 8 * k);
      end
    end
    repeat (300) @(negedge clk);
    checks++;
    if (a_busy !== 1'b1 || a_data !== 10'd48) begin
      errors++;
      $display("FAIL rst_pre got busy=%b data=%0d want 1 48", a_busy, a_data);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (a_ready !== 1'b1 || a_busy !== 1'b0 || a_tick !== 1'b0 || a_load !== 1'b0 || a_data !== 10'd0) begin
      errors++;
      $display("FAIL rst_async got ready=%b busy=%b tick=%b load=%b data=%0d want 1 0 0 0 0",
               a_ready, a_busy, a_tick, a_load, a_data);
    end
    check_init_load();
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_same_target();
    test_stop_priority();
    test_stop_mid_ramp();
    test_boundary();
    test_reset_mid_ramp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pwm_ramp_ctrl.md
PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 SHALL have parameter STEP, default 10'd8, the maximum duty change applied per PWM period (1..1023).
REQ-002 SHALL have port clk  input  1  system clock, the same clock as the PWM block.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port target  input  10  requested final duty value.
REQ-005 SHALL have port target_valid  input  1  high when target is offered.
REQ-006 SHALL have port target_ready  output  1  high when a new target can be accepted.
REQ-007 SHALL have port stop  input  1  synchronous request to ramp down to duty 0.
REQ-008 SHALL have port data_out  output  10  duty value, connected to the PWM data_in.
REQ-009 SHALL have port load  output  1  one-cycle pulse, connected to the PWM load.
REQ-010 SHALL have port busy  output  1  high while ramping.
REQ-011 SHALL have port period_tick  output  1  one-cycle pulse on the last cycle of each 1024-cycle period.

Function
REQ-012 SHALL hold a 10-bit period counter cnt that increments every clk and wraps from 1023 to 0.
REQ-013 SHALL assert period_tick combinationally when cnt==1023.
REQ-014 SHALL implement the states IDLE and RAMP, with target_ready equal to (state==IDLE) and busy equal to (state==RAMP).
REQ-015 SHALL, in IDLE on target_valid&&target_ready, capture target into tgt, go to RAMP if target!=cur, and otherwise stay in IDLE with no load.
REQ-016 SHALL, in RAMP on period_tick, update cur toward tgt by min(STEP, |tgt-cur|), computing the difference in 11 bits so that cur never overflows past 1023 or underflows below 0.
REQ-017 SHALL register load=1 and data_out=new cur in the cycle after each tick that updates cur (the cycle where cnt==0), so that data_out is stable whenever load is high.
REQ-018 SHALL return to IDLE on the same tick on which cur reaches tgt.
REQ-019 SHALL, on stop==1 in any state, set tgt=0 and enter RAMP if cur!=0; stop SHALL take priority over a simultaneous target handshake, which is then not accepted.
REQ-020 SHALL ignore target_valid while in RAMP; a new target is taken only when back in IDLE.
REQ-021 SHALL, on the first period_tick after reset, emit one initial load with data_out=0 so that the PWM duty register is defined.
REQ-022 SHALL keep load low on every cycle other than those given in REQ-017 and REQ-021, and SHALL hold data_out at cur between loads.

Reset
REQ-023 SHALL, while rst_n==0, asynchronously force cnt=0, cur=0, tgt=0, state=IDLE, load=0, data_out=0, and set the init-load-pending flag.
REQ-024 SHALL, on reset asserted mid-ramp, abandon the ramp with no further load until the init load of REQ-021.
REQ-025 SHALL present target_ready=1, busy=0 and period_tick=0 out of reset.

Structure
REQ-026 SHALL take DUTY_W=10, PERIOD_MAX=10'd1023 and the state encoding IDLE/RAMP from the shared package pwm_pkg.
REQ-027 SHALL place the period counter in the sub-module period_timer (outputs cnt and period_tick), reusable by other PWM controllers.
REQ-028 SHALL be implementable in 120-400 lines of RTL, fully synchronous to clk apart from the rst_n reset.

Verification
REQ-029 Release reset, wait for tick -> load=1 with data_out=0 at cycle 1024, and no other load before that cycle.
REQ-030 STEP=8, cur=0, target=20 accepted -> loads of 8, 16, 20 on three consecutive periods, then IDLE with target_ready=1.
REQ-031 cur=20, target=20 offered -> handshake completes, state stays IDLE, and no load is emitted.
REQ-032 cur=1020, target=1023 -> a single load of 1023 with no wrap; then cur=3, target=0 -> a single load of 0.
REQ-033 Mid-ramp 0->100 at cur=40, pulse stop together with target_valid (target=500) -> target not accepted; loads of 32, 24, ..., 0, then IDLE.
REQ-034 Assert rst_n=0 mid-ramp at cur=48 -> all outputs take reset values immediately; the first load after release is 0 at cycle 1024.
